// File: rtl/seq_mul_pkg.sv
// seq_mul_pkg: shared defaults, iteration count and FSM state encoding for seq_mul_unit
package seq_mul_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_ITER = 8;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_WB = 2'd2} state_t;
endpackage

// File: rtl/seq_mul_if.sv
// seq_mul_if: issue (start, signed_op, op_a, op_b, dest_addr) and write-back (busy, wb_write, wb_addr, wb_data, plus wb_data_hi/ovf under SEQ_MUL_HIGH_EN) bundle
interface seq_mul_if
  import seq_mul_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic start;
  logic signed_op;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [ADDR_W-1:0] dest_addr;
  logic busy;
  logic wb_write;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
`ifdef SEQ_MUL_HIGH_EN
  logic [DATA_W-1:0] wb_data_hi;
  logic ovf;
  modport master (output start, signed_op, op_a, op_b, dest_addr,
                  input busy, wb_write, wb_addr, wb_data, wb_data_hi, ovf);
  modport slave (input start, signed_op, op_a, op_b, dest_addr,
                 output busy, wb_write, wb_addr, wb_data, wb_data_hi, ovf);
`else
  modport master (output start, signed_op, op_a, op_b, dest_addr,
                  input busy, wb_write, wb_addr, wb_data);
  modport slave (input start, signed_op, op_a, op_b, dest_addr,
                 output busy, wb_write, wb_addr, wb_data);
`endif
endinterface

// File: rtl/mul_sign_fix.sv
// mul_sign_fix: combinational conditional two's-complement negate (val in, neg in, res out) for operand magnitude and product sign correction
module mul_sign_fix #(
  parameter int W = 8
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);
  assign res = neg ? -val : val;
endmodule

// File: rtl/seq_mul_unit.sv
// seq_mul_unit: 8x8 shift-add multiplier with register-file write-back; ports CLK, RESET, bus (seq_mul_if.slave); SEQ_MUL_HIGH_EN adds wb_data_hi and ovf
module seq_mul_unit
  import seq_mul_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int ITER = DEF_ITER
) (
  input logic CLK,
  input logic RESET,
  seq_mul_if.slave bus
);
  localparam int CW = $clog2(ITER + 1);
  state_t state, state_nx;
  logic [DATA_W-1:0] mcand, mplier, mag_a, mag_b;
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W:0] sum;
  logic [CW-1:0] cnt;
  logic [ADDR_W-1:0] dest;
  logic sign, wb, run_done;
  mul_sign_fix #(.W(DATA_W)) u_fix_a (.val(bus.op_a), .neg(bus.signed_op & bus.op_a[DATA_W-1]), .res(mag_a));
  mul_sign_fix #(.W(DATA_W)) u_fix_b (.val(bus.op_b), .neg(bus.signed_op & bus.op_b[DATA_W-1]), .res(mag_b));
  // RUN holds one extra cycle after the last iteration so WB lands nine edges after the accept
  assign run_done = cnt == CW'(ITER);
  always_ff @(posedge CLK) state <= RESET ? S_IDLE : state_nx;
  always_comb begin
    state_nx = state == S_IDLE ? (bus.start ? S_RUN : S_IDLE) :
               state == S_RUN  ? (run_done ? S_WB : S_RUN) : S_IDLE;
    sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, mplier[0] ? mcand : '0};
  end
`ifdef SEQ_MUL_HIGH_EN
  logic sgn_op;
  logic [2*DATA_W-1:0] prod;
  mul_sign_fix #(.W(2*DATA_W)) u_fix_p (.val(acc), .neg(sign), .res(prod));
  always_ff @(posedge CLK) sgn_op <= RESET ? 1'b0 : (state == S_IDLE && bus.start) ? bus.signed_op : sgn_op;
  assign bus.wb_data_hi = wb ? prod[2*DATA_W-1:DATA_W] : '0;
  assign bus.ovf = wb & (sgn_op ? ~(&prod[2*DATA_W-1:DATA_W-1] | ~|prod[2*DATA_W-1:DATA_W-1])
                                : |prod[2*DATA_W-1:DATA_W]);
`else
  logic [DATA_W-1:0] prod;
  mul_sign_fix #(.W(DATA_W)) u_fix_p (.val(acc[DATA_W-1:0]), .neg(sign), .res(prod));
`endif
  always_ff @(posedge CLK) begin
    if (RESET) begin
      mcand <= '0;
      mplier <= '0;
      sign <= 1'b0;
      dest <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (state == S_IDLE && bus.start) begin
      mcand <= mag_a;
      mplier <= mag_b;
      sign <= bus.signed_op & (bus.op_a[DATA_W-1] ^ bus.op_b[DATA_W-1]);
      dest <= bus.dest_addr;
      acc <= '0;
      cnt <= '0;
    end else if (state == S_RUN && !run_done) begin
      acc <= {sum, acc[DATA_W-1:1]};
      mplier <= mplier >> 1;
      cnt <= cnt + 1'b1;
    end
  end
  assign wb = state == S_WB;
  assign bus.busy = state != S_IDLE;
  assign bus.wb_write = wb;
  assign bus.wb_addr = wb ? dest : '0;
  assign bus.wb_data = wb ? prod[DATA_W-1:0] : '0;
endmodule

// File: tb/tb_seq_mul_unit.sv
// tb_seq_mul_unit: scoreboard bench for seq_mul_unit covering reset, unsigned/signed/truncation, busy-ignore, mid-op reset and back-to-back write-back
module tb_seq_mul_unit;
  typedef struct {
    logic [2:0] addr;
    logic [7:0] lo;
    logic [7:0] hi;
    logic ovf;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  exp_t sb[$];
  logic [7:0] rf_mem [8];
  seq_mul_if #(.DATA_W(8), .ADDR_W(3)) bus ();
  seq_mul_unit dut (.CLK(clk), .RESET(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.wb_write) rf_mem[bus.wb_addr] <= bus.wb_data;
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [2:0] d);
    int p;
    exp_t e;
    p = s ? int'($signed(a)) * int'($signed(b)) : int'(a) * int'(b);
    e.addr = d;
    e.lo = p[7:0];
    e.hi = p[15:8];
    e.ovf = s ? (p < -128 || p > 127) : (p > 255);
    sb.push_back(e);
    bus.op_a = a;
    bus.op_b = b;
    bus.signed_op = s;
    bus.dest_addr = d;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op_a = ~a;
    bus.op_b = ~b;
    bus.signed_op = ~s;
    bus.dest_addr = ~d;
  endtask
  task automatic finish_op(input string nm, input bit hold);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s scoreboard empty", nm);
      return;
    end
    e = sb.pop_front();
    for (int m = 0; m <= 10; m++) begin
      bus.start = hold && m <= 9;
      if (hold) begin
        bus.op_a = 8'd9;
        bus.op_b = 8'd9;
        bus.dest_addr = 3'd7;
      end
      total++;
      if (bus.busy !== (m <= 9)) begin
        bad++;
        $display("FAIL %s busy m=%0d got=%b want=%b", nm, m, bus.busy, m <= 9);
      end
      total++;
      if (bus.wb_write !== (m == 9)) begin
        bad++;
        $display("FAIL %s wb_write m=%0d got=%b want=%b", nm, m, bus.wb_write, m == 9);
      end
      if (m == 9) begin
        total++;
        if (bus.wb_addr !== e.addr) begin
          bad++;
          $display("FAIL %s wb_addr got=%0d want=%0d", nm, bus.wb_addr, e.addr);
        end
        total++;
        if (bus.wb_data !== e.lo) begin
          bad++;
          $display("FAIL %s wb_data got=%h want=%h", nm, bus.wb_data, e.lo);
        end
`ifdef SEQ_MUL_HIGH_EN
        total++;
        if (bus.wb_data_hi !== e.hi) begin
          bad++;
          $display("FAIL %s wb_data_hi got=%h want=%h", nm, bus.wb_data_hi, e.hi);
        end
        total++;
        if (bus.ovf !== e.ovf) begin
          bad++;
          $display("FAIL %s ovf got=%b want=%b", nm, bus.ovf, e.ovf);
        end
`endif
      end
      if (m < 10) @(negedge clk);
    end
    bus.start = 1'b0;
  endtask
  task automatic check_idle(input string nm);
    total++;
    if ({bus.busy, bus.wb_write, bus.wb_addr, bus.wb_data} !== 13'd0) begin
      bad++;
      $display("FAIL %s outputs got busy=%b wr=%b addr=%0d data=%h want all 0", nm, bus.busy, bus.wb_write, bus.wb_addr, bus.wb_data);
    end
`ifdef SEQ_MUL_HIGH_EN
    total++;
    if ({bus.wb_data_hi, bus.ovf} !== 9'd0) begin
      bad++;
      $display("FAIL %s high outputs got hi=%h ovf=%b want 0", nm, bus.wb_data_hi, bus.ovf);
    end
`endif
  endtask
  task automatic quiet(input string nm, input int n);
    bit seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      seen |= bus.wb_write | bus.busy;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL %s spurious activity got=%b want=0", nm, seen);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_unsigned();
    issue(8'd5, 8'd6, 1'b0, 3'd3);
    finish_op("unsigned_5x6", 1'b0);
    issue(8'hFF, 8'hFF, 1'b0, 3'd4);
    finish_op("unsigned_ffxff", 1'b0);
    issue(8'd0, 8'd77, 1'b0, 3'd5);
    finish_op("unsigned_zero", 1'b0);
  endtask
  task automatic test_truncation();
    issue(8'h20, 8'h10, 1'b0, 3'd5);
    finish_op("trunc", 1'b0);
  endtask
  task automatic test_signed();
    issue(8'hFD, 8'h07, 1'b1, 3'd2);
    finish_op("signed_m3x7", 1'b0);
    issue(8'h80, 8'hFF, 1'b1, 3'd4);
    finish_op("signed_m128xm1", 1'b0);
    issue(8'hF6, 8'hF3, 1'b1, 3'd6);
    finish_op("signed_negxneg", 1'b0);
    issue(8'h80, 8'h00, 1'b1, 3'd1);
    finish_op("signed_zero", 1'b0);
  endtask
  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      issue(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      finish_op("random", 1'b0);
    end
  endtask
  task automatic test_busy_ignore();
    issue(8'd5, 8'd7, 1'b0, 3'd1);
    finish_op("busy_ignore", 1'b1);
    quiet("busy_ignore_tail", 12);
  endtask
  task automatic test_reset_mid();
    issue(8'h11, 8'h22, 1'b0, 3'd6);
    void'(sb.pop_front());
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle("reset_mid");
    rst = 1'b0;
    quiet("reset_mid_tail", 12);
  endtask
  task automatic test_back_to_back();
    issue(8'd2, 8'd3, 1'b0, 3'd1);
    finish_op("b2b_first", 1'b0);
    total++;
    if (rf_mem[1] !== 8'd6) begin
      bad++;
      $display("FAIL b2b_r1 got=%0d want=6", rf_mem[1]);
    end
    issue(rf_mem[1], rf_mem[1], 1'b0, 3'd2);
    finish_op("b2b_second", 1'b0);
    total++;
    if (rf_mem[2] !== 8'd36) begin
      bad++;
      $display("FAIL b2b_r2 got=%0d want=36", rf_mem[2]);
    end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.signed_op = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.dest_addr = '0;
    @(negedge clk);
    test_reset();
    test_unsigned();
    test_truncation();
    test_signed();
    test_random();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
